// File: rtl/sent_rx_crc_engine.sv
// Beat-serial LFSR CRC checker for SENT receive frames (one instance per frame type).
// Absorbs DATA_W-bit symbols, optionally appends one zero beat, then reports ok / err / length status.
module sent_rx_crc_engine #(
   parameter int               CRC_W     = 4,
   parameter logic [CRC_W-1:0] POLY      = 4'hD,
   parameter logic [CRC_W-1:0] SEED      = 4'h5,
   parameter int               DATA_W    = 4,
   parameter int               MAX_BEATS = 8,
   parameter int               CNT_W     = 4
) (
   input  logic              clk_rx,
   input  logic              reset_n_rx,
   input  logic              start_i,
   input  logic              augment_i,
   input  logic              data_valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic [CRC_W-1:0]  crc_rx_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              crc_ok_o,
   output logic              crc_err_o,
   output logic              len_err_o,
   output logic [CRC_W-1:0]  crc_calc_o,
   output logic [CNT_W-1:0]  beat_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_AUGMENT = 2'd2,
      ST_REPORT  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CRC_W-1:0] CRC_ZERO = {CRC_W{1'b0}};

   // Table-form step: advance the register by DATA_W shifts, then fold the symbol into the low bits.
   function automatic logic [CRC_W-1:0] f_crc_beat(
      input logic [CRC_W-1:0]  crc_in,
      input logic [DATA_W-1:0] sym
   );
      logic [CRC_W-1:0] c;
      c = crc_in;
      for (int k = 0; k < DATA_W; k++) begin
         if (c[CRC_W-1]) begin
            c = {c[CRC_W-2:0], 1'b0} ^ POLY;
         end else begin
            c = {c[CRC_W-2:0], 1'b0};
         end
      end
      c[DATA_W-1:0] = c[DATA_W-1:0] ^ sym;
      return c;
   endfunction

   state_t           r_state;
   logic [CRC_W-1:0] r_crc;
   logic [CRC_W-1:0] r_crc_rx;
   logic             r_aug;
   logic [CNT_W-1:0] r_beat_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_ok;
   logic             r_err;
   logic             r_len_err;
   logic [CRC_W-1:0] r_crc_calc;

   logic [CRC_W-1:0] w_seed_crc;
   logic [CRC_W-1:0] w_beat_crc;
   logic [CRC_W-1:0] w_aug_crc;
   logic             w_cnt_full;
   logic [CNT_W-1:0] w_cnt_inc;

   // Candidate next CRC values and the saturating beat count.
   always_comb begin
      w_seed_crc = f_crc_beat(SEED, data_i);
      w_beat_crc = f_crc_beat(r_crc, data_i);
      w_aug_crc  = f_crc_beat(r_crc, {DATA_W{1'b0}});
      w_cnt_full = (r_beat_cnt == CNT_MAX);
      if (w_cnt_full) begin
         w_cnt_inc = r_beat_cnt;
      end else begin
         w_cnt_inc = r_beat_cnt + CNT_ONE;
      end
   end

   // Message FSM; the result is registered on entry to REPORT so done_o is high exactly while in REPORT.
   always_ff @(posedge clk_rx or negedge reset_n_rx) begin
      if (!reset_n_rx) begin
         r_state    <= ST_IDLE;
         r_crc      <= SEED;
         r_crc_rx   <= CRC_ZERO;
         r_aug      <= 1'b0;
         r_beat_cnt <= CNT_ZERO;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_len_err  <= 1'b0;
         r_crc_calc <= CRC_ZERO;
      end else begin
         r_done <= 1'b0;
         if (start_i) begin
            // A start aborts whatever was in flight and clears the previous result.
            r_aug      <= augment_i;
            r_busy     <= 1'b1;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_len_err  <= 1'b0;
            r_crc_calc <= CRC_ZERO;
            if (data_valid_i) begin
               r_crc      <= w_seed_crc;
               r_beat_cnt <= CNT_ONE;
               if (last_i) begin
                  r_crc_rx <= crc_rx_i;
                  if (augment_i) begin
                     r_state <= ST_AUGMENT;
                  end else begin
                     r_state    <= ST_REPORT;
                     r_done     <= 1'b1;
                     r_crc_calc <= w_seed_crc;
                     r_ok       <= (w_seed_crc == crc_rx_i);
                     r_err      <= (w_seed_crc != crc_rx_i);
                  end
               end else begin
                  r_state <= ST_ACCUM;
               end
            end else begin
               r_crc      <= SEED;
               r_beat_cnt <= CNT_ZERO;
               r_state    <= ST_ACCUM;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_busy <= 1'b0;
               end
               ST_ACCUM: begin
                  if (data_valid_i) begin
                     if (w_cnt_full && !last_i) begin
                        r_state    <= ST_REPORT;
                        r_done     <= 1'b1;
                        r_len_err  <= 1'b1;
                        r_ok       <= 1'b0;
                        r_err      <= 1'b0;
                        r_crc_calc <= r_crc;
                     end else begin
                        r_crc      <= w_beat_crc;
                        r_beat_cnt <= w_cnt_inc;
                        if (last_i) begin
                           r_crc_rx <= crc_rx_i;
                           if (r_aug) begin
                              r_state <= ST_AUGMENT;
                           end else begin
                              r_state    <= ST_REPORT;
                              r_done     <= 1'b1;
                              r_crc_calc <= w_beat_crc;
                              r_ok       <= (w_beat_crc == crc_rx_i);
                              r_err      <= (w_beat_crc != crc_rx_i);
                           end
                        end else begin
                           r_state <= ST_ACCUM;
                        end
                     end
                  end else begin
                     r_state <= ST_ACCUM;
                  end
               end
               ST_AUGMENT: begin
                  r_crc      <= w_aug_crc;
                  r_state    <= ST_REPORT;
                  r_done     <= 1'b1;
                  r_crc_calc <= w_aug_crc;
                  r_ok       <= (w_aug_crc == r_crc_rx);
                  r_err      <= (w_aug_crc != r_crc_rx);
               end
               ST_REPORT: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign crc_ok_o   = r_ok;
   assign crc_err_o  = r_err;
   assign len_err_o  = r_len_err;
   assign crc_calc_o = r_crc_calc;
   assign beat_cnt_o = r_beat_cnt;

endmodule
